// File: rtl/kmap_chk_pkg.sv
// Shared types and helpers for the K-map response checker: run state encoding,
// counter width default and the care-masked difference function.
package kmap_chk_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int MAX_OUT_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chk_state_t;

   // Operands are widened to MAX_OUT_W; callers cast the result back to their width.
   function automatic logic [MAX_OUT_W-1:0] masked_diff(
      input logic [MAX_OUT_W-1:0] exp_v,
      input logic [MAX_OUT_W-1:0] care_v,
      input logic [MAX_OUT_W-1:0] dut_v
   );
      return (exp_v ^ dut_v) & care_v;
   endfunction

endpackage

// File: rtl/kmap_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module kmap_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   // Clear has priority over increment; the count holds once it reaches all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= {W{1'b0}};
      end else if (clr) begin
         q <= {W{1'b0}};
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + {{(W-1){1'b0}}, 1'b1};
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/kmap_response_checker.sv
// Compares DUT samples against golden values under a care mask, accumulates
// counts, sticky error bits and the first failing index, and latches a verdict.
module kmap_response_checker
   import kmap_chk_pkg::*;
#(
   parameter int OUT_W = 1,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             start,
   input  logic             stop,
   input  logic             in_valid,
   input  logic [OUT_W-1:0] exp_val,
   input  logic [OUT_W-1:0] exp_care,
   input  logic [OUT_W-1:0] dut_val,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] first_err_idx,
   output logic             first_err_vld,
   output logic [OUT_W-1:0] err_bits
);

   chk_state_t       state_r;
   chk_state_t       state_nxt_s;
   logic             start_acc_s;
   logic             stop_acc_s;
   logic             accept_s;
   logic             miss_s;
   logic             err_inc_s;
   logic [OUT_W-1:0] diff_s;

   logic             busy_r;
   logic             done_r;
   logic             pass_r;
   logic             mismatch_r;
   logic [CNT_W-1:0] first_idx_r;
   logic             first_vld_r;
   logic [OUT_W-1:0] err_bits_r;

   assign start_acc_s = start && (state_r != RUN);
   assign stop_acc_s  = stop && (state_r == RUN);
   assign accept_s    = in_valid && (state_r == RUN);
   assign diff_s      = OUT_W'(masked_diff(MAX_OUT_W'(exp_val), MAX_OUT_W'(exp_care),
                                           MAX_OUT_W'(dut_val)));
   assign miss_s      = |diff_s;
   assign err_inc_s   = accept_s && miss_s;

   // Next-state logic; start outranks stop outside RUN, start inside RUN is ignored.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_nxt_s = RUN;
            else       state_nxt_s = IDLE;
         end
         RUN: begin
            if (stop) state_nxt_s = DONE;
            else      state_nxt_s = RUN;
         end
         DONE: begin
            if (start) state_nxt_s = RUN;
            else       state_nxt_s = DONE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register plus registered status flags derived from the next state.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_r    <= IDLE;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         mismatch_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         busy_r     <= (state_nxt_s == RUN);
         done_r     <= (state_nxt_s == DONE);
         mismatch_r <= err_inc_s;
      end
   end

   // Verdict must include a mismatching sample accepted on the stop edge itself.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         pass_r <= 1'b0;
      end else if (start_acc_s) begin
         pass_r <= 1'b0;
      end else if (stop_acc_s) begin
         pass_r <= (err_cnt == {CNT_W{1'b0}}) && !err_inc_s;
      end else begin
         pass_r <= pass_r;
      end
   end

   // Sticky error bits and first-failure capture; the index is the pre-increment count.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         first_idx_r <= {CNT_W{1'b0}};
         first_vld_r <= 1'b0;
         err_bits_r  <= {OUT_W{1'b0}};
      end else if (start_acc_s) begin
         first_idx_r <= {CNT_W{1'b0}};
         first_vld_r <= 1'b0;
         err_bits_r  <= {OUT_W{1'b0}};
      end else if (err_inc_s) begin
         err_bits_r <= err_bits_r | diff_s;
         if (!first_vld_r) begin
            first_idx_r <= sample_cnt;
            first_vld_r <= 1'b1;
         end else begin
            first_idx_r <= first_idx_r;
            first_vld_r <= first_vld_r;
         end
      end else begin
         first_idx_r <= first_idx_r;
         first_vld_r <= first_vld_r;
         err_bits_r  <= err_bits_r;
      end
   end

   kmap_sat_counter #(.W(CNT_W)) u_sample_cnt (
      .clk (clk),
      .rst (areset),
      .clr (start_acc_s),
      .inc (accept_s),
      .q   (sample_cnt)
   );

   kmap_sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk (clk),
      .rst (areset),
      .clr (start_acc_s),
      .inc (err_inc_s),
      .q   (err_cnt)
   );

   assign busy          = busy_r;
   assign done          = done_r;
   assign pass          = pass_r & done_r;
   assign mismatch      = mismatch_r;
   assign first_err_idx = first_idx_r;
   assign first_err_vld = first_vld_r;
   assign err_bits      = err_bits_r;

endmodule

// File: tb/tb_kmap_response_checker.sv
// Scoreboard bench for kmap_response_checker: a wide-counter and a 4-bit-counter
// instance share the stimulus and are compared against a behavioural model.
module tb_kmap_response_checker;

   logic        clk = 1'b0;
   logic        areset;
   logic        start;
   logic        stop;
   logic        in_valid;
   logic [0:0]  exp_val;
   logic [0:0]  exp_care;
   logic [0:0]  dut_val;

   logic        busy, done, pass, mismatch, first_err_vld;
   logic [15:0] sample_cnt, err_cnt, first_err_idx;
   logic [0:0]  err_bits;

   logic        s_busy, s_done, s_pass, s_mismatch, s_first_err_vld;
   logic [3:0]  s_sample_cnt, s_err_cnt, s_first_err_idx;
   logic [0:0]  s_err_bits;

   int n_checks = 0;
   int n_fail   = 0;

   bit q_exp[$];

   int m_state;
   int m_samples;
   int m_errs;
   int m_first;
   bit m_vld;
   bit m_bits;

   always #5 clk = ~clk;

   kmap_response_checker #(.OUT_W(1), .CNT_W(16)) dut (
      .clk(clk), .areset(areset), .start(start), .stop(stop), .in_valid(in_valid),
      .exp_val(exp_val), .exp_care(exp_care), .dut_val(dut_val),
      .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
      .sample_cnt(sample_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
      .first_err_vld(first_err_vld), .err_bits(err_bits)
   );

   kmap_response_checker #(.OUT_W(1), .CNT_W(4)) sat_dut (
      .clk(clk), .areset(areset), .start(start), .stop(stop), .in_valid(in_valid),
      .exp_val(exp_val), .exp_care(exp_care), .dut_val(dut_val),
      .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch(s_mismatch),
      .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt), .first_err_idx(s_first_err_idx),
      .first_err_vld(s_first_err_vld), .err_bits(s_err_bits)
   );

   function automatic int sat(input int x, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (x > mx) ? mx : x;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_checks++;
      if (obs !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, req);
      end
   endtask

   task automatic model_reset();
      m_state   = 0;
      m_samples = 0;
      m_errs    = 0;
      m_first   = 0;
      m_vld     = 1'b0;
      m_bits    = 1'b0;
   endtask

   task automatic check_all(input string t);
      check_val({t, ":busy"},    32'(busy),          32'(m_state == 1));
      check_val({t, ":done"},    32'(done),          32'(m_state == 2));
      check_val({t, ":pass"},    32'(pass),          32'((m_state == 2) && (m_errs == 0)));
      check_val({t, ":samples"}, 32'(sample_cnt),    32'(sat(m_samples, 16)));
      check_val({t, ":errs"},    32'(err_cnt),       32'(sat(m_errs, 16)));
      check_val({t, ":fidx"},    32'(first_err_idx), 32'(sat(m_first, 16)));
      check_val({t, ":fvld"},    32'(first_err_vld), 32'(m_vld));
      check_val({t, ":bits"},    32'(err_bits),      32'(m_bits));
      check_val({t, ":s_pass"},    32'(s_pass),          32'((m_state == 2) && (m_errs == 0)));
      check_val({t, ":s_samples"}, 32'(s_sample_cnt),    32'(sat(m_samples, 4)));
      check_val({t, ":s_errs"},    32'(s_err_cnt),       32'(sat(m_errs, 4)));
      check_val({t, ":s_fidx"},    32'(s_first_err_idx), 32'(sat(m_first, 4)));
   endtask

   // One clock: drive inputs, push the expected mismatch flag, advance the model, compare.
   task automatic cycle(input string t, input bit v, input bit e, input bit c, input bit d,
                        input bit st, input bit sp);
      bit miss;
      bit exp_m;
      in_valid = v; exp_val = e; exp_care = c; dut_val = d; start = st; stop = sp;
      miss = ((e ^ d) & c) != 1'b0;
      if (v && m_state == 1) begin
         q_exp.push_back(miss);
         if (miss) begin
            m_errs++;
            m_bits = m_bits | ((e ^ d) & c);
            if (!m_vld) begin
               m_first = m_samples;
               m_vld   = 1'b1;
            end
         end
         m_samples++;
      end else begin
         q_exp.push_back(1'b0);
      end
      if (st && m_state != 1) begin
         m_state   = 1;
         m_samples = 0;
         m_errs    = 0;
         m_first   = 0;
         m_vld     = 1'b0;
         m_bits    = 1'b0;
      end else if (sp && m_state == 1) begin
         m_state = 2;
      end
      @(posedge clk);
      #1;
      exp_m = q_exp.pop_front();
      check_val({t, ":mismatch"},   32'(mismatch),   32'(exp_m));
      check_val({t, ":s_mismatch"}, 32'(s_mismatch), 32'(exp_m));
      check_all(t);
      in_valid = 1'b0; start = 1'b0; stop = 1'b0;
   endtask

   task automatic idle(input string t);
      cycle(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      areset = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
      exp_val = 1'b0; exp_care = 1'b0; dut_val = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      areset = 1'b0;
      check_all("reset");
      check_val("reset:mismatch", 32'(mismatch), 32'd0);

      // all samples match
      cycle("t1_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         cycle("t1", 1'b1, i[0], 1'b1, i[0], 1'b0, 1'b0);
      end
      cycle("t1_stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle("t1_hold");
      check_val("t1_done",    32'(done),          32'd1);
      check_val("t1_pass",    32'(pass),          32'd1);
      check_val("t1_samples", 32'(sample_cnt),    32'd16);
      check_val("t1_errs",    32'(err_cnt),       32'd0);
      check_val("t1_fvld",    32'(first_err_vld), 32'd0);

      // differences under a zero care mask are ignored
      cycle("t2_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         if (i == 2 || i == 7 || i == 11) cycle("t2_dc", 1'b1, i[1], 1'b0, ~i[1], 1'b0, 1'b0);
         else                             cycle("t2",    1'b1, i[1], 1'b1,  i[1], 1'b0, 1'b0);
      end
      cycle("t2_stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_val("t2_errs", 32'(err_cnt),  32'd0);
      check_val("t2_bits", 32'(err_bits), 32'd0);
      check_val("t2_pass", 32'(pass),     32'd1);

      // mismatches at samples 5 and 9, with an idle gap inside the run
      cycle("t3_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle("t3", 1'b1, 1'b1, 1'b1, (i == 5 || i == 9) ? 1'b0 : 1'b1, 1'b0, 1'b0);
         if (i == 6) idle("t3_gap");
      end
      cycle("t3_stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_val("t3_errs", 32'(err_cnt),       32'd2);
      check_val("t3_fidx", 32'(first_err_idx), 32'd5);
      check_val("t3_fvld", 32'(first_err_vld), 32'd1);
      check_val("t3_bits", 32'(err_bits),      32'd1);
      check_val("t3_pass", 32'(pass),          32'd0);

      // mismatching sample accepted together with stop
      cycle("t4_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle("t4_last", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check_val("t4_errs", 32'(err_cnt), 32'd1);
      check_val("t4_done", 32'(done),    32'd1);
      check_val("t4_pass", 32'(pass),    32'd0);

      // start and stop together from DONE: start wins
      cycle("t5_both", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_val("t5_busy", 32'(busy),          32'd1);
      check_val("t5_errs", 32'(err_cnt),       32'd0);
      check_val("t5_fvld", 32'(first_err_vld), 32'd0);
      cycle("t5_ignored_start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      cycle("t5_stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("t5_ignored_stop", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

      // saturation on the 4-bit instance
      cycle("t6_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cycle("t6", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      cycle("t6_stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_val("t6_s_samples", 32'(s_sample_cnt),    32'd15);
      check_val("t6_s_errs",    32'(s_err_cnt),       32'd15);
      check_val("t6_s_fidx",    32'(s_first_err_idx), 32'd0);
      check_val("t6_samples",   32'(sample_cnt),      32'd20);

      // asynchronous reset in the middle of a run
      cycle("t7_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         cycle("t7", 1'b1, 1'b1, 1'b1, (i == 3) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      end
      areset = 1'b1;
      #1;
      model_reset();
      q_exp.delete();
      check_all("t7_rst");
      check_val("t7_rst_busy",     32'(busy),       32'd0);
      check_val("t7_rst_samples",  32'(sample_cnt), 32'd0);
      check_val("t7_rst_mismatch", 32'(mismatch),   32'd0);
      @(posedge clk);
      #1;
      areset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle("t7_nostart", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      check_val("t7_post_samples", 32'(sample_cnt), 32'd0);
      check_val("t7_post_done",    32'(done),       32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
